mod_updown_counter: RTL and testbench

Parametrised up/down counter with programmable modulus, parallel load, synchronous clear and selectable wrap or saturate behaviour. It generalises the team's fixed 4-bit free-running counter into a reusable timebase and event-count primitive for testbench and datapath use. All state is single-clock, with a synchronous active-high reset.

---
 rtl/mod_updown_counter.sv | 70 +++++++
 tb/tb_mod_updown_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable inclusive bound, parallel load, soft clear
// and a wrap-or-saturate boundary policy; tc pulses on boundary steps, ovf is sticky.
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  logic             at_top;
  logic             at_bottom;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] up_bound_val;
  logic [WIDTH-1:0] down_bound_val;

  // ">=" rather than "==" so a count stranded above a lowered max_val
  // still treats the next up step as a boundary step.
  assign at_top         = (count >= max_val);
  assign at_bottom      = (count == '0);
  assign load_clamped   = (load_val > max_val) ? max_val : load_val;
  assign up_bound_val   = SATURATE ? max_val : '0;
  assign down_bound_val = SATURATE ? '0 : max_val;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= RST_COUNT;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          count <= up_bound_val;
          tc    <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count + 1'b1;
          tc    <= 1'b0;
        end
      end else begin
        if (at_bottom) begin
          count <= down_bound_val;
          tc    <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count - 1'b1;
          tc    <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: a wrap instance and a saturate instance share
// stimulus and are checked every cycle against an integer-arithmetic model.
module tb_mod_updown_counter;

  localparam int W  = 4;
  localparam int RV = 3;

  logic         clk;
  logic         reset;
  logic         clr;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] max_val;
  logic [W-1:0] count_w;
  logic         tc_w;
  logic         ovf_w;
  logic [W-1:0] count_s;
  logic         tc_s;
  logic         ovf_s;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mod_updown_counter #(.WIDTH(W), .RESET_VAL(RV), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(count_w), .tc(tc_w), .ovf(ovf_w)
  );

  mod_updown_counter #(.WIDTH(W), .RESET_VAL(RV), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(count_s), .tc(tc_s), .ovf(ovf_s)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (index 0 = wrap, 1 = saturate) ----------------
  int m_cnt [2];
  int m_tc  [2];
  int m_ovf [2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int c, nxt, mx, t, o;
      c  = m_cnt[k];
      o  = m_ovf[k];
      t  = 0;
      mx = int'(max_val);
      if (reset || clr) begin
        c = RV;
        o = 0;
      end else if (load) begin
        c = (int'(load_val) < mx) ? int'(load_val) : mx;
      end else if (en) begin
        nxt = up ? c + 1 : c - 1;
        if ((up && nxt > mx) || (!up && nxt < 0)) begin
          t = 1;
          o = 1;
          if (k == 1) c = up ? mx : 0;
          else        c = up ? 0 : mx;
        end else begin
          c = nxt;
        end
      end
      m_cnt[k] <= c;
      m_tc[k]  <= t;
      m_ovf[k] <= o;
    end
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_count_wrap", int'(count_w), m_cnt[0]);
      chk("model_tc_wrap",    int'(tc_w),    m_tc[0]);
      chk("model_ovf_wrap",   int'(ovf_w),   m_ovf[0]);
      chk("model_count_sat",  int'(count_s), m_cnt[1]);
      chk("model_tc_sat",     int'(tc_s),    m_tc[1]);
      chk("model_ovf_sat",    int'(ovf_s),   m_ovf[1]);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0;
    load_val = '0; max_val = 4'd15;

    // reset held with en high
    step(); step();
    chk("rst_count_w", int'(count_w), 3);
    chk("rst_count_s", int'(count_s), 3);
    chk("rst_tc_w", int'(tc_w), 0);
    chk("rst_ovf_w", int'(ovf_w), 0);

    reset = 1'b0;
    step(); step();
    chk("two_up_w", int'(count_w), 5);
    chk("two_up_s", int'(count_s), 5);

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_count_w", int'(count_w), 3);
    chk("clr_ovf_w", int'(ovf_w), 0);

    // wrap up through max_val = 9
    max_val = 4'd9; load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    chk("wrap_start", int'(count_w), 0);
    for (int i = 1; i <= 11; i++) begin
      step();
      chk("wrap_up_count", int'(count_w), i % 10);
      chk("wrap_up_tc", int'(tc_w), (i == 10) ? 1 : 0);
    end
    chk("wrap_up_ovf", int'(ovf_w), 1);

    // wrap down from 1
    load = 1'b1; load_val = 4'd1;
    step();
    load = 1'b0; up = 1'b0;
    step();
    chk("wrap_dn_c0", int'(count_w), 0);
    chk("wrap_dn_t0", int'(tc_w), 0);
    step();
    chk("wrap_dn_c1", int'(count_w), 9);
    chk("wrap_dn_t1", int'(tc_w), 1);
    step();
    chk("wrap_dn_c2", int'(count_w), 8);
    chk("wrap_dn_t2", int'(tc_w), 0);

    // saturate at 15
    clr = 1'b1;
    step();
    clr = 1'b0; max_val = 4'd15; load = 1'b1; load_val = 4'd14;
    step();
    load = 1'b0; up = 1'b1;
    chk("sat_ovf_clear", int'(ovf_s), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sat_count", int'(count_s), 15);
      chk("sat_tc", int'(tc_s), (i > 0) ? 1 : 0);
    end
    up = 1'b0;
    step();
    chk("sat_dn_count", int'(count_s), 14);
    chk("sat_dn_tc", int'(tc_s), 0);
    chk("sat_dn_ovf", int'(ovf_s), 1);

    // load clamp and clr-over-load priority
    max_val = 4'd7; load = 1'b1; load_val = 4'd12; en = 1'b1;
    step();
    chk("load_clamp_w", int'(count_w), 7);
    chk("load_clamp_s", int'(count_s), 7);
    chk("load_tc_w", int'(tc_w), 0);
    clr = 1'b1;
    step();
    clr = 1'b0; load = 1'b0;
    chk("clr_over_load", int'(count_w), 3);

    // max_val lowered below the count
    max_val = 4'd15; load = 1'b1; load_val = 4'd8;
    step();
    load = 1'b0; max_val = 4'd5; up = 1'b1;
    step();
    chk("lower_wrap", int'(count_w), 0);
    chk("lower_sat", int'(count_s), 5);
    chk("lower_tc_w", int'(tc_w), 1);
    chk("lower_tc_s", int'(tc_s), 1);

    // max_val == 0: every step is a boundary step
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0; max_val = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("zero_max_count_w", int'(count_w), 0);
      chk("zero_max_count_s", int'(count_s), 0);
      chk("zero_max_tc_w", int'(tc_w), 1);
    end

    // reset beats clr/load/en
    reset = 1'b1; clr = 1'b1; load = 1'b1; load_val = 4'd9; max_val = 4'd15;
    step();
    reset = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
    chk("rst_override", int'(count_w), 3);
    chk("rst_override_ovf", int'(ovf_w), 0);
    step();
    chk("hold_count", int'(count_w), 3);
    chk("hold_tc", int'(tc_w), 0);

    // randomized traffic checked by the model
    for (int i = 0; i < 2000; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      clr      = ($urandom_range(0, 99) < 3);
      load     = ($urandom_range(0, 99) < 8);
      en       = ($urandom_range(0, 99) < 80);
      up       = ($urandom_range(0, 99) < 60);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5)
        max_val = ($urandom_range(0, 3) == 0) ? 4'd15 : W'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
